// File: rtl/calc_pkg.sv
// Shared definitions for the decimal-entry and display-side fixed-point logic.
// Holds the converter state encoding, the number-base constants and the
// 10.6 fixed-point field widths, plus a BCD digit validity helper.
package calc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INT   = 2'd1,
        ST_FRAC  = 2'd2,
        ST_ROUND = 2'd3
    } state_e;

    localparam int DEC_BASE = 10;
    localparam int FRAC_DEN = 100;
    localparam int INT_MAX  = 1023;
    localparam int FRAC_W   = 6;
    localparam int INT_W    = 10;

    // 9999 needs 14 bits; 99 needs 7 bits.
    localparam int ACC_W    = 14;
    localparam int REM_W    = 7;
    localparam int DIG_W    = 4;
    localparam int CNT_W    = 3;

    function automatic logic bcd_bad(input logic [DIG_W-1:0] d);
        return d > 4'd9;
    endfunction

endpackage

// File: rtl/frac_bcd_to_bin.sv
// Two-digit decimal fraction (0..99 hundredths) to 6-bit binary fraction.
// Restoring successive doubling: each step doubles the remainder and emits a
// 1 when it reaches one whole (100 hundredths), MSB first. The final remainder
// decides round-half-up.
// Ports:
//   clk, rst        clock, async active-low reset
//   load, load_val  start a new fraction from load_val hundredths (0..99)
//   step            produce the next fraction bit
//   fin             conversion consumed; clear the working registers
//   frac_out        rounded fraction, valid once all steps are done
module frac_bcd_to_bin
    import calc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [REM_W-1:0]  load_val,
    input  logic              step,
    input  logic              fin,
    output logic [FRAC_W-1:0] frac_out
);

    logic [REM_W-1:0]  rem_q, rem_d;
    logic [FRAC_W-1:0] bits_q, bits_d;
    logic [REM_W:0]    rem_x2;
    logic              ge_one;
    logic              round_up;

    assign rem_x2 = {rem_q, 1'b0};
    assign ge_one = rem_x2 >= (REM_W+1)'(FRAC_DEN);

    always_comb begin
        rem_d  = rem_q;
        bits_d = bits_q;
        if (fin) begin
            rem_d  = '0;
            bits_d = '0;
        end else if (load) begin
            rem_d  = load_val;
            bits_d = '0;
        end else if (step) begin
            bits_d = {bits_q[FRAC_W-2:0], ge_one};
            if (ge_one) begin
                rem_d = REM_W'(rem_x2 - (REM_W+1)'(FRAC_DEN));
            end else begin
                rem_d = rem_x2[REM_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q  <= '0;
            bits_q <= '0;
        end else begin
            rem_q  <= rem_d;
            bits_q <= bits_d;
        end
    end

    // Twice the leftover remainder >= one whole means the dropped tail is at
    // least half an LSB. The largest input (.99) cannot reach 63.5, but the
    // increment still saturates so the field can never wrap.
    assign round_up = ge_one;

    always_comb begin
        frac_out = bits_q;
        if (round_up && (bits_q != {FRAC_W{1'b1}})) begin
            frac_out = bits_q + FRAC_W'(1);
        end
    end

endmodule

// File: rtl/decimal_entry_to_fixed.sv
// Converts keypad/switch BCD entry dddd.dd into unsigned 10.6 fixed point.
// Integer part via Horner accumulation (one digit per cycle), fraction via
// the frac_bcd_to_bin sub-module. 12 cycles per conversion, 2 on bad digits.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | waiting for start; latches digits when it arrives
//   ST_INT   | 4 cycles, acc = acc*10 + digit, thousands first
//   ST_FRAC  | 6 cycles, one binary fraction bit per cycle
//   ST_ROUND | round, saturate or flag bad digit, write outputs, pulse done
//
// Ports:
//   clk, rst                    clock, async active-low reset
//   start                       conversion request, sampled only in idle
//   dig_th/dig_h/dig_t/dig_o    integer BCD digits
//   dig_f1/dig_f2               tenths / hundredths BCD digits
//   busy                        conversion in progress
//   done                        one-cycle pulse, new outputs valid
//   err                         bad digit or saturated result
//   left_side, right_side       10-bit integer, 6-bit fraction (1/64)
module decimal_entry_to_fixed
    import calc_pkg::*;
#(
    parameter int INT_MAX   = calc_pkg::INT_MAX,
    parameter int FRAC_BITS = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DIG_W-1:0]     dig_th,
    input  logic [DIG_W-1:0]     dig_h,
    input  logic [DIG_W-1:0]     dig_t,
    input  logic [DIG_W-1:0]     dig_o,
    input  logic [DIG_W-1:0]     dig_f1,
    input  logic [DIG_W-1:0]     dig_f2,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [INT_W-1:0]     left_side,
    output logic [FRAC_BITS-1:0] right_side
);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [DIG_W-1:0]       digs_q [6];
    logic [DIG_W-1:0]       digs_d [6];
    logic                   bad_q, bad_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [INT_W-1:0]       left_q, left_d;
    logic [FRAC_BITS-1:0]   right_q, right_d;

    logic                   frac_load;
    logic                   frac_step;
    logic                   frac_fin;
    logic [REM_W-1:0]       frac_init;
    logic [FRAC_W-1:0]      frac_val;

    // Hundredths value of the latched fraction digits (0..99).
    assign frac_init = REM_W'(digs_q[4]) * REM_W'(DEC_BASE) + REM_W'(digs_q[5]);

    frac_bcd_to_bin u_frac (
        .clk      (clk),
        .rst      (rst),
        .load     (frac_load),
        .load_val (frac_init),
        .step     (frac_step),
        .fin      (frac_fin),
        .frac_out (frac_val)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        digs_d    = digs_q;
        bad_d     = bad_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        left_d    = left_q;
        right_d   = right_q;
        frac_load = 1'b0;
        frac_step = 1'b0;
        frac_fin  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    digs_d[0] = dig_th;
                    digs_d[1] = dig_h;
                    digs_d[2] = dig_t;
                    digs_d[3] = dig_o;
                    digs_d[4] = dig_f1;
                    digs_d[5] = dig_f2;
                    acc_d     = '0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    bad_d     = bcd_bad(dig_th) | bcd_bad(dig_h) | bcd_bad(dig_t)
                              | bcd_bad(dig_o) | bcd_bad(dig_f1) | bcd_bad(dig_f2);
                    state_d   = bad_d ? ST_ROUND : ST_INT;
                end
            end

            ST_INT: begin
                acc_d = acc_q * ACC_W'(DEC_BASE) + ACC_W'(digs_q[cnt_q]);
                if (cnt_q == CNT_W'(3)) begin
                    cnt_d     = '0;
                    frac_load = 1'b1;
                    state_d   = ST_FRAC;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_FRAC: begin
                frac_step = 1'b1;
                if (cnt_q == CNT_W'(FRAC_W - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_ROUND;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_ROUND: begin
                frac_fin = 1'b1;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
                if (bad_q) begin
                    left_d  = '0;
                    right_d = '0;
                    err_d   = 1'b1;
                end else if (acc_q > ACC_W'(INT_MAX)) begin
                    left_d  = INT_W'(INT_MAX);
                    right_d = {FRAC_BITS{1'b1}};
                    err_d   = 1'b1;
                end else begin
                    left_d  = acc_q[INT_W-1:0];
                    right_d = FRAC_BITS'(frac_val);
                    err_d   = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            for (int i = 0; i < 6; i++) begin
                digs_q[i] <= '0;
            end
            bad_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            left_q  <= '0;
            right_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            digs_q  <= digs_d;
            bad_q   <= bad_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            left_q  <= left_d;
            right_q <= right_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign left_side  = left_q;
    assign right_side = right_q;

endmodule

// File: tb/tb_decimal_entry_to_fixed.sv
module tb_decimal_entry_to_fixed;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] dig_th, dig_h, dig_t, dig_o, dig_f1, dig_f2;
    logic       busy, done, err;
    logic [9:0] left_side;
    logic [5:0] right_side;

    int vectors;
    int miscompares;
    int lat;
    int n_done;
    int done_edge;

    decimal_entry_to_fixed dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dig_th     (dig_th),
        .dig_h      (dig_h),
        .dig_t      (dig_t),
        .dig_o      (dig_o),
        .dig_f1     (dig_f1),
        .dig_f2     (dig_f2),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .left_side  (left_side),
        .right_side (right_side)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Starts one conversion, scrambles the digit inputs after the start edge,
    // and returns the number of edges from the start edge to done (40 = none).
    task automatic run(input logic [3:0] th, h, t, o, f1, f2, output int edges);
        @(negedge clk);
        dig_th = th; dig_h = h; dig_t = t; dig_o = o; dig_f1 = f1; dig_f2 = f2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dig_th = 4'd7; dig_h = 4'd7; dig_t = 4'd7; dig_o = 4'd7; dig_f1 = 4'd7; dig_f2 = 4'd7;
        edges = 40;
        for (int i = 1; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                edges = i;
                break;
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b0;
        start = 1'b0;
        dig_th = 0; dig_h = 0; dig_t = 0; dig_o = 0; dig_f1 = 0; dig_f2 = 0;
        #23;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_left", left_side, 0);
        check("rst_right", right_side, 0);
        @(negedge clk);
        rst = 1'b1;

        // 0012.50 with latency and busy checks
        @(negedge clk);
        dig_th = 0; dig_h = 0; dig_t = 1; dig_o = 2; dig_f1 = 5; dig_f2 = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_e0", busy, 1);
        lat = 40;
        for (int i = 1; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
        check("lat_12_50", lat, 11);
        check("left_12_50", left_side, 12);
        check("right_12_50", right_side, 32);
        check("err_12_50", err, 0);
        check("busy_at_done", busy, 0);
        @(posedge clk);
        #1;
        check("done_drops", done, 0);
        check("hold_left", left_side, 12);

        run(1, 0, 2, 3, 9, 9, lat);
        check("lat_1023_99", lat, 11);
        check("left_1023_99", left_side, 1023);
        check("right_1023_99", right_side, 63);
        check("err_1023_99", err, 0);

        run(0, 0, 0, 0, 0, 1, lat);
        check("right_01", right_side, 1);
        check("left_01", left_side, 0);
        run(0, 0, 0, 0, 1, 0, lat);
        check("right_10", right_side, 6);
        run(0, 0, 0, 0, 1, 5, lat);
        check("right_15", right_side, 10);
        run(0, 0, 0, 0, 2, 5, lat);
        check("right_25", right_side, 16);

        run(1, 0, 2, 4, 0, 0, lat);
        check("left_1024", left_side, 1023);
        check("right_1024", right_side, 63);
        check("err_1024", err, 1);

        run(9, 9, 9, 9, 9, 9, lat);
        check("left_9999", left_side, 1023);
        check("right_9999", right_side, 63);
        check("err_9999", err, 1);

        run(0, 3, 4'hA, 1, 2, 5, lat);
        check("lat_bad", lat, 1);
        check("err_bad", err, 1);
        check("left_bad", left_side, 0);
        check("right_bad", right_side, 0);

        // good run to leave nonzero outputs, then reset mid-conversion
        run(0, 3, 2, 1, 2, 5, lat);
        check("left_321_25", left_side, 321);
        check("err_321_25", err, 0);
        @(negedge clk);
        dig_th = 0; dig_h = 5; dig_t = 0; dig_o = 0; dig_f1 = 7; dig_f2 = 5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i <= 5; i++) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) n_done++;
        end
        check("rst_mid_dones", n_done, 0);
        check("rst_mid_left", left_side, 0);
        check("rst_mid_right", right_side, 0);
        check("rst_mid_err", err, 0);
        check("rst_mid_busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;

        run(0, 5, 0, 0, 7, 5, lat);
        check("left_500_75", left_side, 500);
        check("right_500_75", right_side, 48);

        // start pulses while busy are ignored
        @(negedge clk);
        dig_th = 0; dig_h = 0; dig_t = 1; dig_o = 2; dig_f1 = 5; dig_f2 = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_done = 0;
        done_edge = 0;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            start = (i == 3 || i == 6 || i == 9 || i == 11) ? 1'b1 : 1'b0;
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                n_done++;
                done_edge = i;
            end
        end
        start = 1'b0;
        check("busy_start_dones", n_done, 1);
        check("busy_start_edge", done_edge, 11);
        check("busy_start_left", left_side, 12);
        check("busy_start_right", right_side, 32);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
